csi_tx_lane_dist: RTL and testbench
===================================

# csi_tx_lane_dist

Transmit-side lane distributor for the CSI-2 bridge. It takes packet words (one byte per lane) from the packet builder and runs the HS burst framing on every lane: prepare, 0xB8 sync byte, payload, trail. A per-lane programmable skew of 0–2 byte clocks is applied at the output, so the transmit path can exercise the receiver's lane deskew. It sits between the packet builder and the per-lane serializers.

## Interface
- NUM_LANES, 2: number of data lanes (1..4).
- HS_PREP_CYCLES, 4: byte clocks of HS-prepare (lanes idle, hs_valid low) before the sync byte; ≥1.
- TRAIL_CYCLES, 2: byte clocks of HS-trail after the last payload byte; ≥1.

- byte_clock  in  1  byte clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  starts a burst; sampled only in IDLE.
- word_in  in  NUM_LANES*8  payload word; byte i goes to lane i (bits 8i+7:8i).
- word_valid  in  1  word_in valid.
- word_end  in  1  qualifies the last word of the packet; meaningful with word_valid.
- word_ready  out  1  word accepted on edges where word_valid & word_ready.
- lane_skew  in  NUM_LANES*2  per-lane extra delay (bits 2i+1:2i); value 3 is treated as 2.
- byte_out  out  NUM_LANES*8  per-lane HS byte to the serializers.
- hs_valid  out  NUM_LANES  per-lane HS-active flag.
- busy  out  1  high from burst start until every lane's hs_valid has gone low.
- underrun  out  1  one-cycle pulse when a word was missing in DATA.

## Operation
- FSM states: IDLE, PREP, SYNC, DATA, TRAIL.
- IDLE:
  - word_ready=0.
  - On an edge with enable & word_valid, latch lane_skew, load the prep counter with HS_PREP_CYCLES-1, and go to PREP.
  - The word is not consumed.
- PREP: counts down. At 0, go to SYNC. Output stage loads 0x00 with hs_valid=0.
- SYNC:
  - One cycle.
  - Output stage loads 0xB8 on all lanes with hs_valid=1.
  - word_ready=0.
  - Go to DATA.
- DATA:
  - word_ready=1 (combinational on state).
  - On a handshake, the output stage loads word_in with hs_valid=1.
  - If word_end is set, load the trail counter with TRAIL_CYCLES-1 and go to TRAIL.
  - If word_valid=0 at an edge, this is an underrun:
    - underrun pulses for one cycle;
    - the output loads trail bytes;
    - go to TRAIL with the counter loaded with TRAIL_CYCLES-2, saturating at 0.
- TRAIL:
  - Each lane outputs {8{~b7}}, where b7 is bit 7 of the last HS byte sent on that lane (bytes are serialized LSB first).
  - hs_valid=1.
  - At counter 0, go to IDLE. The next output load is 0x00 with hs_valid=0.
- Skew stage:
  - Lane i's {hs_valid, byte} passes through a delay line of latched skew[i] registers after the common output register.
  - Skew changes take effect only at the next burst start.
- busy = (state≠IDLE) | any delayed hs_valid.
- A new burst may not start while busy. IDLE additionally requires busy=0 before accepting enable.
- enable deasserting mid-burst has no effect; the packet completes.
- reset (at any time, including mid-burst):
  - state goes to IDLE;
  - byte_out, hs_valid, busy, underrun, word_ready and all delay registers go to 0 on the same edge;
  - no trail is emitted.

## Timing
- Number edges from E0, the IDLE edge that samples enable & word_valid. P=HS_PREP_CYCLES, T=TRAIL_CYCLES.
- For a skew-0 lane:
  - hs_valid rises and byte_out=0xB8 at E(P+1);
  - the first payload byte appears at E(P+2) (first handshake at E(P+2));
  - payload is contiguous while word_valid stays high.
- The last word accepted at Ek appears at Ek. Trail bytes appear at E(k+1)…E(k+T). hs_valid falls at E(k+T+1).
- A lane with skew s shows the identical sequence shifted by s edges.
- busy falls at E(k+T+1+max skew).
- word_ready to data-out latency: 0 extra cycles. Data is registered at the handshake edge.

## Structure
- Package csi_tx_pkg holds:
  - SYNC_BYTE = 8'hB8;
  - the FSM state enum;
  - MAX_SKEW = 2.
- Sub-module csi_tx_lane_skew: a single-lane 0..2-cycle delay line for {hs_valid, byte[7:0]}, with synchronous reset. It is instantiated NUM_LANES times in a generate loop.

## Test plan
- Basic burst:
  - Setup: NUM_LANES=2, P=4, T=2, skew 0/0; words 0x1211, 0x2221 (end).
  - Expected lane0: 0xB8, 0x11, 0x21, then 0xFF, 0xFF (bit7 of 0x21 is 0). Expected lane1: 0xB8, 0x12, 0x22, then 0xFF, 0xFF.
  - hs_valid spans E5..E9.
- Skewed lanes:
  - Setup: skew lane0=2, lane1=0; same packet.
  - Expected: lane0 sequence is lane1's shifted by 2 edges.
  - busy falls at E12.
- Trail polarity: last byte 0x80 on lane0 -> trail 0x00, 0x00.
- Underrun:
  - Stimulus: word_valid drops after the first data word.
  - Expected: underrun pulses once, trail begins the next edge, hs_valid falls after T total trail cycles, and no data is lost before the drop.
- Reset mid-DATA:
  - Stimulus: assert reset during payload.
  - Expected: all outputs are 0 on the next edge, there is no trail, and a new burst starts normally afterwards.
- Back-to-back / enable-while-busy:
  - Stimulus: hold enable and word_valid high continuously.
  - Expected: the second burst's PREP starts only after busy=0, and skew re-latched at the new E0 takes effect.

Source files
------------

// File: rtl/csi_tx_pkg.sv
// Shared constants and state encoding for the CSI-2 transmit lane distributor.
package csi_tx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;
    localparam int         MAX_SKEW  = 2;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        SYNC,
        DATA,
        TRAIL
    } tx_state_e;

    // A programmed skew of 3 behaves as the maximum supported skew.
    function automatic logic [1:0] clamp_skew(input logic [1:0] raw);
        return (raw > 2'(MAX_SKEW)) ? 2'(MAX_SKEW) : raw;
    endfunction

endpackage

// File: rtl/csi_tx_lane_skew.sv
// Single-lane 0..2 byte-clock delay line for {hs_valid, byte}.
module csi_tx_lane_skew
    import csi_tx_pkg::*;
(
    input  logic       byte_clock,
    input  logic       reset,
    input  logic [1:0] skew,
    input  logic       hs_in,
    input  logic [7:0] byte_in,
    output logic       hs_out,
    output logic [7:0] byte_out
);

    logic [8:0] dly1;
    logic [8:0] dly2;

    // Stages beyond the selected skew are held at zero, so a skew change at
    // the next burst start never exposes stale HS state from an unused stage.
    always_ff @(posedge byte_clock) begin
        if (reset) begin
            dly1 <= '0;
            dly2 <= '0;
        end else begin
            dly1 <= (skew != 2'd0) ? {hs_in, byte_in} : 9'd0;
            dly2 <= (skew == 2'(MAX_SKEW)) ? dly1 : 9'd0;
        end
    end

    always_comb begin
        case (skew)
            2'd0:    {hs_out, byte_out} = {hs_in, byte_in};
            2'd1:    {hs_out, byte_out} = dly1;
            default: {hs_out, byte_out} = dly2;
        endcase
    end

endmodule

// File: rtl/csi_tx_lane_dist.sv
// CSI-2 transmit lane distributor: HS burst framing (prepare, sync, payload,
// trail) on every lane, followed by a per-lane programmable output skew.
module csi_tx_lane_dist
    import csi_tx_pkg::*;
#(
    parameter int NUM_LANES      = 2,
    parameter int HS_PREP_CYCLES = 4,
    parameter int TRAIL_CYCLES   = 2
) (
    input  logic                   byte_clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_LANES*8-1:0] word_in,
    input  logic                   word_valid,
    input  logic                   word_end,
    output logic                   word_ready,
    input  logic [NUM_LANES*2-1:0] lane_skew,
    output logic [NUM_LANES*8-1:0] byte_out,
    output logic [NUM_LANES-1:0]   hs_valid,
    output logic                   busy,
    output logic                   underrun
);

    localparam int CNT_MAX = (HS_PREP_CYCLES > TRAIL_CYCLES) ? HS_PREP_CYCLES : TRAIL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PREP_LOAD     = CNT_W'(HS_PREP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAIL_LOAD    = CNT_W'(TRAIL_CYCLES - 1);
    // The underrun edge itself already emits the first trail byte.
    localparam logic [CNT_W-1:0] TRAIL_LOAD_UR = (TRAIL_CYCLES >= 2) ? CNT_W'(TRAIL_CYCLES - 2) : '0;

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_LANES*8-1:0] obyte_q, obyte_d;
    logic                   ohs_q, ohs_d;
    logic [NUM_LANES-1:0]   msb_q, msb_d;
    logic [NUM_LANES*2-1:0] skew_q, skew_d;
    logic                   underrun_q, underrun_d;
    logic [NUM_LANES*8-1:0] trail_word;

    // Trail drives the complement of the last serialized bit (bit 7, LSB-first).
    always_comb begin
        trail_word = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            trail_word[8*i +: 8] = {8{~msb_q[i]}};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        obyte_d    = obyte_q;
        ohs_d      = ohs_q;
        msb_d      = msb_q;
        skew_d     = skew_q;
        underrun_d = 1'b0;
        word_ready = 1'b0;

        case (state_q)
            IDLE: begin
                obyte_d = '0;
                ohs_d   = 1'b0;
                if (enable && word_valid && !busy) begin
                    state_d = PREP;
                    cnt_d   = PREP_LOAD;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        skew_d[2*i +: 2] = clamp_skew(lane_skew[2*i +: 2]);
                    end
                end
            end

            PREP: begin
                obyte_d = '0;
                ohs_d   = 1'b0;
                if (cnt_q == '0) begin
                    state_d = SYNC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            SYNC: begin
                obyte_d = {NUM_LANES{SYNC_BYTE}};
                ohs_d   = 1'b1;
                msb_d   = {NUM_LANES{SYNC_BYTE[7]}};
                state_d = DATA;
            end

            DATA: begin
                word_ready = 1'b1;
                ohs_d      = 1'b1;
                if (word_valid) begin
                    obyte_d = word_in;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        msb_d[i] = word_in[8*i + 7];
                    end
                    if (word_end) begin
                        state_d = TRAIL;
                        cnt_d   = TRAIL_LOAD;
                    end
                end else begin
                    underrun_d = 1'b1;
                    obyte_d    = trail_word;
                    state_d    = TRAIL;
                    cnt_d      = TRAIL_LOAD_UR;
                end
            end

            TRAIL: begin
                obyte_d = trail_word;
                ohs_d   = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge byte_clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            obyte_q    <= '0;
            ohs_q      <= 1'b0;
            msb_q      <= '0;
            skew_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            obyte_q    <= obyte_d;
            ohs_q      <= ohs_d;
            msb_q      <= msb_d;
            skew_q     <= skew_d;
            underrun_q <= underrun_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        csi_tx_lane_skew u_skew (
            .byte_clock (byte_clock),
            .reset      (reset),
            .skew       (skew_q[2*g +: 2]),
            .hs_in      (ohs_q),
            .byte_in    (obyte_q[8*g +: 8]),
            .hs_out     (hs_valid[g]),
            .byte_out   (byte_out[8*g +: 8])
        );
    end

    assign busy     = (state_q != IDLE) | (|hs_valid);
    assign underrun = underrun_q;

endmodule

// File: tb/tb_csi_tx_lane_dist.sv
// Scoreboard bench for csi_tx_lane_dist: a burst-level model predicts each
// lane's HS byte stream with absolute edge numbers; a monitor checks them.
module tb_csi_tx_lane_dist;

    localparam int NL = 2;
    localparam int P  = 4;
    localparam int T  = 2;

    logic            byte_clock = 1'b0;
    logic            reset      = 1'b1;
    logic            enable     = 1'b0;
    logic [NL*8-1:0] word_in    = '0;
    logic            word_valid = 1'b0;
    logic            word_end   = 1'b0;
    logic            word_ready;
    logic [NL*2-1:0] lane_skew  = '0;
    logic [NL*8-1:0] byte_out;
    logic [NL-1:0]   hs_valid;
    logic            busy;
    logic            underrun;

    csi_tx_lane_dist #(
        .NUM_LANES      (NL),
        .HS_PREP_CYCLES (P),
        .TRAIL_CYCLES   (T)
    ) dut (
        .byte_clock (byte_clock),
        .reset      (reset),
        .enable     (enable),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_end   (word_end),
        .word_ready (word_ready),
        .lane_skew  (lane_skew),
        .byte_out   (byte_out),
        .hs_valid   (hs_valid),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 byte_clock = ~byte_clock;

    typedef struct packed {
        logic [31:0] edge_n;
        logic [7:0]  b;
    } exp_t;

    exp_t            exp_q [NL][$];
    int              ur_q[$];
    logic [NL*8-1:0] words[$];
    int              cyc    = 0;
    int              errors = 0;
    int              checks = 0;
    bit              mon_en = 1'b0;

    always @(posedge byte_clock) cyc <= cyc + 1;

    // Monitor: every lane with hs_valid high must match the next predicted byte and edge.
    always @(negedge byte_clock) begin
        if (mon_en) begin
            for (int i = 0; i < NL; i++) begin
                exp_t       e;
                logic [7:0] got;
                got = byte_out[8*i +: 8];
                if (hs_valid[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL lane%0d_extra_hs: edge %0d byte %h, nothing expected", i, cyc, got);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (int'(e.edge_n) != cyc || got !== e.b) begin
                            errors++;
                            $display("FAIL lane%0d_byte: got %h at edge %0d, expected %h at edge %0d",
                                     i, got, cyc, e.b, e.edge_n);
                        end
                    end
                end else begin
                    checks++;
                    if (got !== 8'h00) begin
                        errors++;
                        $display("FAIL lane%0d_idle_byte: got %h at edge %0d, expected 00", i, got, cyc);
                    end
                    if (exp_q[i].size() > 0 && int'(exp_q[i][0].edge_n) <= cyc) begin
                        e = exp_q[i].pop_front();
                        errors++;
                        $display("FAIL lane%0d_missing_hs: hs_valid low at edge %0d, expected %h at edge %0d",
                                 i, cyc, e.b, e.edge_n);
                    end
                end
            end
            if (underrun) begin
                checks++;
                if (ur_q.size() == 0) begin
                    errors++;
                    $display("FAIL underrun_extra: pulse at edge %0d, none expected", cyc);
                end else if (ur_q[0] != cyc) begin
                    errors++;
                    $display("FAIL underrun_edge: pulse at edge %0d, expected edge %0d", cyc, ur_q[0]);
                    void'(ur_q.pop_front());
                end else begin
                    void'(ur_q.pop_front());
                end
            end else if (ur_q.size() > 0 && ur_q[0] <= cyc) begin
                checks++;
                errors++;
                $display("FAIL underrun_missing: no pulse at edge %0d, expected edge %0d", cyc, ur_q[0]);
                void'(ur_q.pop_front());
            end
        end
    end

    task automatic push_exp(input int lane, input int edge_n, input logic [7:0] b, input int cut);
        exp_t e;
        if (cut == 0 || edge_n < cut) begin
            e.edge_n = 32'(edge_n);
            e.b      = b;
            exp_q[lane].push_back(e);
        end
    endtask

    // Burst model: sync at E(P+1), payload from E(P+2), T trail bytes right
    // after the last accepted word (or at the underrun edge), lane shifted by skew.
    task automatic model_burst(input int e0, input logic [NL*2-1:0] skw, input int first,
                               input int n, input bit drop, input int cut, output int busy_fall);
        int              s;
        int              maxs;
        int              tstart;
        logic [7:0]      last;
        logic [7:0]      bv;
        logic [NL*8-1:0] w;
        maxs   = 0;
        tstart = e0 + P + 2 + n;
        for (int i = 0; i < NL; i++) begin
            s = int'(skw[2*i +: 2]);
            if (s > 2) s = 2;
            if (s > maxs) maxs = s;
            last = 8'hB8;
            push_exp(i, e0 + P + 1 + s, 8'hB8, cut);
            for (int j = 0; j < n; j++) begin
                w  = words[first + j];
                bv = w[8*i +: 8];
                push_exp(i, e0 + P + 2 + j + s, bv, cut);
                last = bv;
            end
            for (int t = 0; t < T; t++) begin
                push_exp(i, tstart + t + s, last[7] ? 8'h00 : 8'hFF, cut);
            end
        end
        if (drop && (cut == 0 || tstart < cut)) ur_q.push_back(tstart);
        busy_fall = (cut != 0) ? cut : tstart + T + maxs;
    endtask

    task automatic drive(input int first, input int n, input bit drop, input int rst_after,
                         input int mid_end, input int skew_after, input logic [NL*2-1:0] new_skew,
                         input bit hold);
        int guard;
        enable     = 1'b1;
        word_valid = 1'b1;
        word_in    = words[first];
        word_end   = ((n == 1) && !drop) || (mid_end == 0);
        for (int j = 0; j < n; j++) begin
            guard = 0;
            while (!word_ready && guard < 60) begin
                @(negedge byte_clock);
                guard++;
            end
            checks++;
            if (!word_ready) begin
                errors++;
                $display("FAIL handshake_timeout: word %0d never accepted, word_ready=%b expected 1", j, word_ready);
                enable     = 1'b0;
                word_valid = 1'b0;
                return;
            end
            @(posedge byte_clock);
            #1;
            if (!hold) enable = 1'b0;
            if (skew_after == j + 1) lane_skew = new_skew;
            if (rst_after == j + 1) begin
                reset      = 1'b1;
                enable     = 1'b0;
                word_valid = 1'b0;
                @(posedge byte_clock);
                #1;
                reset = 1'b0;
                return;
            end
            if (j + 1 < n) begin
                word_in  = words[first + j + 1];
                word_end = ((j + 2 == n) && !drop) || (mid_end == j + 1);
            end else begin
                enable     = 1'b0;
                word_valid = 1'b0;
                word_end   = 1'b0;
            end
        end
    endtask

    task automatic wait_busy_fall(input int expect_edge);
        int guard;
        guard = 0;
        @(negedge byte_clock);
        while (busy && guard < 80) begin
            @(negedge byte_clock);
            guard++;
        end
        checks++;
        if (busy || cyc != expect_edge) begin
            errors++;
            $display("FAIL busy_fall: busy=%b fell at edge %0d, expected fall at edge %0d", busy, cyc, expect_edge);
        end
    endtask

    task automatic run_burst(input int first, input int n, input bit drop, input int rst_after,
                             input logic [NL*2-1:0] skw);
        int e0;
        int cut;
        int bf;
        @(negedge byte_clock);
        lane_skew = skw;
        e0  = cyc + 1;
        cut = (rst_after > 0) ? e0 + P + 2 + rst_after : 0;
        model_burst(e0, skw, first, n, drop, cut, bf);
        drive(first, n, drop, rst_after, -1, 1, NL*2'($urandom), 1'b0);
        wait_busy_fall(bf);
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        if (hs_valid !== '0 || byte_out !== '0 || busy !== 1'b0 || word_ready !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL %s: hs=%b bytes=%h busy=%b ready=%b underrun=%b, expected all zero",
                     tag, hs_valid, byte_out, busy, word_ready, underrun);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int              first;
        int              n;
        int              e0;
        int              bf1;
        int              bf2;
        bit              drop;
        logic [NL*2-1:0] skw;

        repeat (3) @(posedge byte_clock);
        @(negedge byte_clock);
        check_quiet("reset_state");
        reset = 1'b0;
        @(negedge byte_clock);
        check_quiet("idle_after_reset");
        mon_en = 1'b1;

        // Basic burst, skew 0/0
        first = words.size();
        words.push_back(16'h1211);
        words.push_back(16'h2221);
        run_burst(first, 2, 1'b0, 0, 4'b0000);

        // Skewed lanes: lane0=2, lane1=0
        run_burst(first, 2, 1'b0, 0, 4'b0010);

        // Trail polarity: lane0 last byte 0x80
        first = words.size();
        words.push_back(16'h5580);
        run_burst(first, 1, 1'b0, 0, 4'b0100);

        // Underrun after the first data word
        first = words.size();
        words.push_back(16'h34B3);
        run_burst(first, 1, 1'b1, 0, 4'b0001);

        // Reset during payload, then a normal burst
        first = words.size();
        words.push_back(16'hA1B2);
        words.push_back(16'hC3D4);
        words.push_back(16'hE5F6);
        words.push_back(16'h0718);
        run_burst(first, 4, 1'b0, 2, 4'b0001);
        check_quiet("after_mid_burst_reset");
        run_burst(first, 4, 1'b0, 0, 4'b1001);

        // Back-to-back with enable/word_valid held; skew changes mid-burst
        first = words.size();
        words.push_back(16'h1357);
        words.push_back(16'h2468);
        words.push_back(16'h9ABC);
        words.push_back(16'hDEF0);
        words.push_back(16'h8081);
        @(negedge byte_clock);
        lane_skew = 4'b0000;
        e0 = cyc + 1;
        model_burst(e0, 4'b0000, first, 2, 1'b0, 0, bf1);
        model_burst(bf1 + 1, 4'b0111, first + 2, 3, 1'b0, 0, bf2);
        drive(first, 5, 1'b0, 0, 1, 1, 4'b0111, 1'b1);
        wait_busy_fall(bf2);

        // Randomized bursts
        for (int r = 0; r < 10; r++) begin
            first = words.size();
            n     = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) words.push_back(16'($urandom));
            drop = ($urandom_range(0, 3) == 0);
            skw  = 4'($urandom);
            run_burst(first, n, drop, 0, skw);
        end

        repeat (5) @(negedge byte_clock);
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL lane%0d_leftover: %0d bytes never seen, expected 0", i, exp_q[i].size());
            end
        end
        checks++;
        if (ur_q.size() != 0) begin
            errors++;
            $display("FAIL underrun_leftover: %0d pulses never seen, expected 0", ur_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
